// File: rtl/arbiter_rr_nx1.sv
// Round-robin N-to-1 bus arbiter with atomic-sequence locking; optional slave-ack timeout under ARB_TIMEOUT_EN.
// Latency: one cycle from request to grant; slave signals and the master return path are combinational while granted.
// Backpressure: the granted master is held until the slave acks, the master withdraws, or the timeout fires.
module arbiter_rr_nx1 #(
    parameter int N_MASTERS = 4,
    parameter int ID_W      = $clog2(N_MASTERS),
    parameter int LOCK_MAX  = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_MASTERS-1:0]      i_bus_en,
    input  logic [N_MASTERS-1:0]      i_wr_rd,
    input  logic [32*N_MASTERS-1:0]   i_wr_data,
    input  logic [32*N_MASTERS-1:0]   i_addr,
    input  logic [4*N_MASTERS-1:0]    i_byte_en,
    input  logic [N_MASTERS-1:0]      i_atomic,
    input  logic [7*N_MASTERS-1:0]    i_operation,
    output logic [N_MASTERS-1:0]      o_ack,
    output logic [32*N_MASTERS-1:0]   o_rd_data,
    input  logic                      i_ack,
    input  logic [31:0]               i_rd_data,
    output logic                      o_bus_en,
    output logic                      o_wr_en,
    output logic                      o_atomic,
    output logic [31:0]               o_wr_data,
    output logic [31:0]               o_addr,
    output logic [3:0]                o_byte_en,
    output logic [6:0]                o_operation,
    output logic [ID_W-1:0]           o_id,
    output logic                      o_timeout
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_LOCK} state_t;

    typedef struct packed {
        logic        wr;
        logic        atomic;
        logic [6:0]  op;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdat;
    } req_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] grant, grant_nxt;
    logic [ID_W-1:0] last, last_nxt;
    logic [LCW-1:0]  lock_cnt, lock_nxt;
    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] cand;
    logic            tmo_hit;
    req_t            req_a [N_MASTERS];
    req_t            sel;

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_req
        assign req_a[k] = {i_wr_rd[k], i_atomic[k], i_operation[7*k +: 7],
                           i_byte_en[4*k +: 4], i_addr[32*k +: 32], i_wr_data[32*k +: 32]};
    end
    assign sel = req_a[grant];

    // Rotating priority: search starts just after the last master served.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = ID_W'((int'(last) + 1 + i) % N_MASTERS);
            if (!win_vld && i_bus_en[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            tmo_cnt <= '0;
        else if (state != ST_GRANT)
            tmo_cnt <= '0;
        else if (!i_ack)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = (state == ST_GRANT) && i_bus_en[grant] && !i_ack &&
                     (tmo_cnt == 16'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            last     <= ID_W'(N_MASTERS - 1);
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        lock_nxt  = lock_cnt;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_nxt = win_id;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_ack) begin
                    last_nxt = grant;
                    if (i_atomic[grant]) begin
                        state_nxt = ST_LOCK;
                        lock_nxt  = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (!i_bus_en[grant]) begin
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    last_nxt  = grant;
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOCK: begin
                // The locked master keeps the bus; everyone else waits.
                if (i_bus_en[grant])
                    state_nxt = ST_GRANT;
                else if (!i_atomic[grant] || lock_cnt == LCW'(LOCK_MAX - 1))
                    state_nxt = ST_IDLE;
                else
                    lock_nxt = lock_cnt + LCW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_bus_en    = 1'b0;
        o_wr_en     = 1'b0;
        o_atomic    = 1'b0;
        o_wr_data   = '0;
        o_addr      = '0;
        o_byte_en   = '0;
        o_operation = '0;
        o_id        = '0;
        if (state == ST_GRANT) begin
            o_bus_en    = i_bus_en[grant] & ~i_ack & ~tmo_hit;
            o_wr_en     = sel.wr;
            o_atomic    = sel.atomic;
            o_wr_data   = sel.wdat;
            o_addr      = sel.addr;
            o_byte_en   = sel.be;
            o_operation = sel.op;
            o_id        = grant;
        end
    end

    assign o_timeout = tmo_hit;

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_ret
        logic own;
        assign own                  = (state == ST_GRANT) && (grant == ID_W'(k));
        assign o_ack[k]             = own & (i_ack | tmo_hit);
        assign o_rd_data[32*k +: 32] = !own   ? 32'h0 :
                                       tmo_hit ? 32'hDEADBEEF : i_rd_data;
    end

endmodule

// File: tb/tb_arbiter_rr_nx1.sv
// Scoreboard bench for arbiter_rr_nx1: expected grant ids are queued when requests are driven and popped on each ack.
module tb_arbiter_rr_nx1;

    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int TMO  = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_bus_en, i_wr_rd, i_atomic;
    logic [32*N-1:0]   i_wr_data, i_addr;
    logic [4*N-1:0]    i_byte_en;
    logic [7*N-1:0]    i_operation;
    logic [N-1:0]      o_ack;
    logic [32*N-1:0]   o_rd_data;
    logic              i_ack;
    logic [31:0]       i_rd_data;
    logic              o_bus_en, o_wr_en, o_atomic, o_timeout;
    logic [31:0]       o_wr_data, o_addr;
    logic [3:0]        o_byte_en;
    logic [6:0]        o_operation;
    logic [ID_W-1:0]   o_id;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 i_clk = ~i_clk;

    arbiter_rr_nx1 #(.N_MASTERS(N), .ID_W(ID_W), .LOCK_MAX(16), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_bus_en(i_bus_en), .i_wr_rd(i_wr_rd), .i_wr_data(i_wr_data), .i_addr(i_addr),
        .i_byte_en(i_byte_en), .i_atomic(i_atomic), .i_operation(i_operation),
        .o_ack(o_ack), .o_rd_data(o_rd_data), .i_ack(i_ack), .i_rd_data(i_rd_data),
        .o_bus_en(o_bus_en), .o_wr_en(o_wr_en), .o_atomic(o_atomic),
        .o_wr_data(o_wr_data), .o_addr(o_addr), .o_byte_en(o_byte_en),
        .o_operation(o_operation), .o_id(o_id), .o_timeout(o_timeout)
    );

    function automatic logic [32*N-1:0] rd_vec(input int id, input logic [31:0] d);
        logic [32*N-1:0] v;
        v = '0;
        v[id*32 +: 32] = d;
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_bus_en = '0; i_atomic = '0; i_ack = 1'b0; i_rd_data = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_bus_en = '1; i_atomic = '1; i_ack = 1'b1; i_rd_data = 32'h1234_5678;
        #1;
        checks++;
        if ({o_bus_en, o_wr_en, o_atomic, o_timeout} !== 4'b0 || o_ack !== '0 || o_id !== '0) begin
            errors++; $display("FAIL reset_ctrl: bus_en=%b ack=%b id=%0d timeout=%b required all 0", o_bus_en, o_ack, o_id, o_timeout);
        end
        checks++;
        if (o_rd_data !== '0 || o_addr !== '0 || o_wr_data !== '0 || o_byte_en !== '0 || o_operation !== '0) begin
            errors++; $display("FAIL reset_data: rd_data=%h addr=%h required 0", o_rd_data, o_addr);
        end
        tick();
        checks++;
        if (o_bus_en !== 1'b0 || o_ack !== '0) begin
            errors++; $display("FAIL reset_clocked: bus_en=%b ack=%b required 0", o_bus_en, o_ack);
        end
        i_bus_en = '0; i_atomic = '0; i_ack = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    // seq holds expected grant ids, one per nibble, first grant in the low nibble.
    task automatic test_round_robin(input string tag, input logic [N-1:0] req, input logic [31:0] seq, input int n);
        logic bus_seen;
        int e;
        do_reset();
        for (int i = 0; i < n; i++) exp_q.push_back(int'(seq[4*i +: 4]));
        i_bus_en = req;
        bus_seen = 1'b0;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            tick();
            i_ack = bus_seen;
            i_rd_data = 32'h5A5A_0000 + 32'(c);
            @(negedge i_clk);
            bus_seen = o_bus_en;
            if (o_bus_en) begin
                checks++;
                if (o_id !== ID_W'(exp_q[0]) || o_addr !== i_addr[exp_q[0]*32 +: 32]) begin
                    errors++; $display("FAIL %s_grant: id=%0d addr=%h required id=%0d addr=%h", tag, o_id, o_addr, exp_q[0], i_addr[exp_q[0]*32 +: 32]);
                end
            end
            if (o_ack !== '0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_ack !== N'(1 << e) || o_id !== ID_W'(e)) begin
                    errors++; $display("FAIL %s_ack: ack=%b id=%0d required ack=%b id=%0d", tag, o_ack, o_id, N'(1 << e), e);
                end
                checks++;
                if (o_rd_data !== rd_vec(e, i_rd_data)) begin
                    errors++; $display("FAIL %s_rdata: rd_data=%h required %h", tag, o_rd_data, rd_vec(e, i_rd_data));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL %s_drain: %0d grants outstanding, required 0", tag, exp_q.size());
        end
        exp_q.delete();
        tick();
        i_ack = 1'b0; i_bus_en = '0;
    endtask

    task automatic test_atomic_lock();
        logic bus_seen;
        int e, acks, wait_c;
        do_reset();
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
        i_bus_en = 4'b0010; i_atomic = 4'b0010;
        bus_seen = 1'b0; acks = 0; wait_c = 0;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            tick();
            i_ack = bus_seen;
            i_rd_data = 32'hA700_0000 + 32'(c);
            if (acks == 1) begin
                wait_c++;
                if (wait_c == 1) begin i_bus_en[1] = 1'b0; i_bus_en[2] = 1'b1; end
                if (wait_c == 3) begin i_bus_en[1] = 1'b1; i_atomic[1] = 1'b0; end
            end
            if (acks == 2) i_bus_en[1] = 1'b0;
            @(negedge i_clk);
            bus_seen = o_bus_en;
            if (acks == 1 && wait_c <= 3) begin
                checks++;
                if (o_bus_en !== 1'b0 || o_ack !== '0) begin
                    errors++; $display("FAIL lock_hold: bus_en=%b ack=%b required 0 while locked", o_bus_en, o_ack);
                end
            end
            if (o_bus_en) begin
                checks++;
                if (o_id !== ID_W'(exp_q[0])) begin
                    errors++; $display("FAIL lock_grant: id=%0d required %0d", o_id, exp_q[0]);
                end
                if (acks == 0) begin
                    checks++;
                    if ({o_wr_en, o_atomic, o_addr, o_operation, o_byte_en, o_wr_data} !==
                        {1'b0, 1'b1, 32'h100, i_operation[13:7], i_byte_en[7:4], i_wr_data[63:32]}) begin
                        errors++; $display("FAIL lock_attrs: wr=%b atomic=%b addr=%h op=%h required wr=0 atomic=1 addr=100 op=%h", o_wr_en, o_atomic, o_addr, o_operation, i_operation[13:7]);
                    end
                end
            end
            if (o_ack !== '0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_ack !== N'(1 << e)) begin
                    errors++; $display("FAIL lock_ack: ack=%b required %b", o_ack, N'(1 << e));
                end
                acks++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL lock_drain: %0d grants outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
        tick();
        i_ack = 1'b0; i_bus_en = '0; i_atomic = '0;
    endtask

    task automatic test_lock_expire();
        logic bus_seen;
        int e, acks, ack_c;
        do_reset();
        exp_q.push_back(1); exp_q.push_back(2);
        i_bus_en = 4'b0010; i_atomic = 4'b0010;
        bus_seen = 1'b0; acks = 0; ack_c = -10;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            tick();
            i_ack = bus_seen;
            if (acks == 1 && ack_c == c - 1) i_bus_en = 4'b0100;
            @(negedge i_clk);
            bus_seen = o_bus_en;
            if (o_bus_en && acks == 1) begin
                checks++;
                if (c - ack_c != 18 || o_id !== 2'd2) begin
                    errors++; $display("FAIL lock_expire: grant id=%0d after %0d cycles, required id=2 after 18", o_id, c - ack_c);
                end
            end
            if (o_ack !== '0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_ack !== N'(1 << e)) begin
                    errors++; $display("FAIL expire_ack: ack=%b required %b", o_ack, N'(1 << e));
                end
                acks++;
                if (acks == 1) ack_c = c;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL expire_drain: %0d grants outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
        tick();
        i_ack = 1'b0; i_bus_en = '0; i_atomic = '0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int g1, k, e;
        logic reached;
        do_reset();
        exp_q.push_back(0);
        i_bus_en = 4'b0011;
        g1 = -1; reached = 1'b0;
        for (int c = 0; c < 60 && !reached; c++) begin
            tick();
            @(negedge i_clk);
            if (g1 < 0 && o_bus_en) g1 = c;
            if (g1 >= 0) begin
                k = c - g1;
                if (k < 7) begin
                    checks++;
                    if ({o_timeout, o_bus_en, o_ack} !== {1'b0, 1'b1, 4'b0}) begin
                        errors++; $display("FAIL tmo_wait: cycle %0d timeout=%b bus_en=%b ack=%b required 0,1,0000", k, o_timeout, o_bus_en, o_ack);
                    end
                end
                if (k == 7) begin
                    checks++;
                    if ({o_timeout, o_bus_en} !== 2'b10 || o_rd_data !== rd_vec(0, 32'hDEADBEEF)) begin
                        errors++; $display("FAIL tmo_fire: timeout=%b bus_en=%b rd_data=%h required 1,0,deadbeef in slot 0", o_timeout, o_bus_en, o_rd_data);
                    end
                end
                if (o_ack !== '0 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (o_ack !== N'(1 << e) || k != 7) begin
                        errors++; $display("FAIL tmo_ack: ack=%b at cycle %0d required %b at cycle 7", o_ack, k, N'(1 << e));
                    end
                end
                if (k == 9) begin
                    reached = 1'b1;
                    checks++;
                    if (o_bus_en !== 1'b1 || o_id !== 2'd1) begin
                        errors++; $display("FAIL tmo_next: bus_en=%b id=%0d required 1, id 1", o_bus_en, o_id);
                    end
                end
            end
        end
        checks++;
        if (!reached || exp_q.size() != 0) begin
            errors++; $display("FAIL tmo_budget: reached=%b outstanding=%0d required 1, 0", reached, exp_q.size());
        end
        exp_q.delete();
        i_bus_en = '0;
    endtask
`else
    task automatic test_timeout();
        int spurious;
        do_reset();
        i_bus_en = 4'b0001;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            @(negedge i_clk);
            if (o_timeout !== 1'b0 || o_ack !== '0) spurious++;
        end
        checks++;
        if (spurious != 0 || o_bus_en !== 1'b1 || o_id !== 2'd0) begin
            errors++; $display("FAIL no_timeout: %0d spurious acks, bus_en=%b id=%0d required 0, 1, 0", spurious, o_bus_en, o_id);
        end
        i_bus_en = '0;
    endtask
`endif

    task automatic test_reset_mid();
        logic bus_seen, done;
        int e;
        do_reset();
        exp_q.push_back(2);
        i_bus_en = 4'b0100;
        bus_seen = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            i_ack = bus_seen;
            i_rd_data = 32'h0000_0077;
            @(negedge i_clk);
            bus_seen = o_bus_en;
            if (o_ack !== '0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_ack !== N'(1 << e)) begin
                    errors++; $display("FAIL rstmid_ack: ack=%b required %b", o_ack, N'(1 << e));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rstmid_drain: %0d outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
        tick();
        i_ack = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge i_clk);
            done = o_bus_en;
        end
        checks++;
        if (!done || o_id !== 2'd2) begin
            errors++; $display("FAIL rstmid_regrant: bus_en=%b id=%0d required 1, id 2", done, o_id);
        end
        i_ack = 1'b1;
        i_rst = 1'b0;
        #1;
        checks++;
        if ({o_bus_en, o_timeout} !== 2'b00 || o_ack !== '0 || o_id !== '0 || o_rd_data !== '0 || o_addr !== '0) begin
            errors++; $display("FAIL rstmid_async: bus_en=%b ack=%b id=%0d rd=%h addr=%h required all 0", o_bus_en, o_ack, o_id, o_rd_data, o_addr);
        end
        tick();
        i_ack = 1'b0;
        i_bus_en = '1;
        @(negedge i_clk);
        i_rst = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge i_clk);
            done = o_bus_en;
        end
        checks++;
        if (!done || o_id !== 2'd0) begin
            errors++; $display("FAIL rstmid_priority: bus_en=%b id=%0d required 1, id 0", done, o_id);
        end
        tick();
        i_bus_en = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b0;
        i_bus_en = '0; i_atomic = '0; i_ack = 1'b0; i_rd_data = '0;
        i_wr_rd = 4'b1001;
        for (int k = 0; k < N; k++) begin
            i_addr[k*32 +: 32]      = 32'h1000 + 32'(k) * 32'h10;
            i_wr_data[k*32 +: 32]   = 32'hC0DE_0000 + 32'(k);
            i_byte_en[k*4 +: 4]     = 4'(4'hF >> k);
            i_operation[k*7 +: 7]   = 7'(k + 5);
        end
        i_addr[63:32] = 32'h0000_0100;

        test_reset();
        test_round_robin("alt", 4'b0101, 32'h0000_2020, 4);
        test_round_robin("all", 4'b1111, 32'h0000_3210, 5);
        test_atomic_lock();
        test_lock_expire();
        test_timeout();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
